// File: rtl/piso_shift_controller.sv
// piso_shift_controller: sequences an N-bit LSB-first serializer. A parallel
// word is accepted over valid/ready, then shifted out at one bit per DIV
// clocks. A one-cycle done pulse follows a frame that completes normally, and
// abort cancels the frame in progress.
// Optional feature: define PISO_SHIFT_CTRL_PARITY_EN to append an even-parity
// bit after the last data bit.
module piso_shift_controller #(
   parameter int N   = 8,
   parameter int DIV = 4
) (
   input  logic         clk,
   input  logic         n_reset,
   input  logic [N-1:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         abort,
   output logic         serial_out,
   output logic         shift_strobe,
   output logic         busy,
   output logic         done
);

   localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int BCW = $clog2(N);
   localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);
   localparam logic [BCW-1:0] BIT_LAST = BCW'(N - 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SHIFT  = 2'd1;
`ifdef PISO_SHIFT_CTRL_PARITY_EN
   localparam logic [1:0] ST_PARITY = 2'd2;
`endif

   logic [1:0]     state_q, state_d;
   logic [N-1:0]   sreg_q, sreg_d;
   logic [DCW-1:0] div_cnt_q, div_cnt_d;
   logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
   logic           done_q, done_d;
`ifdef PISO_SHIFT_CTRL_PARITY_EN
   logic           par_q, par_d;
`endif

   // Last cycle of a bit period; the strobe is this, unless abort cancels it.
   logic period_end;
   assign period_end   = (state_q != ST_IDLE) && (div_cnt_q == DIV_LAST);
   assign shift_strobe = period_end && !abort;
   assign in_ready     = (state_q == ST_IDLE) && !abort;
   assign busy         = (state_q != ST_IDLE);
   assign done         = done_q;

   // Line level: idle high, current data bit, or the parity bit.
   always_comb begin
      serial_out = 1'b1;
      case (state_q)
         ST_SHIFT:  serial_out = sreg_q[0];
`ifdef PISO_SHIFT_CTRL_PARITY_EN
         ST_PARITY: serial_out = par_q;
`endif
         default:   serial_out = 1'b1;
      endcase
   end

   // Next-state logic for the frame sequencer, counters and shift register.
   always_comb begin
      state_d   = state_q;
      sreg_d    = sreg_q;
      div_cnt_d = div_cnt_q;
      bit_cnt_d = bit_cnt_q;
      done_d    = 1'b0;
`ifdef PISO_SHIFT_CTRL_PARITY_EN
      par_d     = par_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (in_valid && in_ready) begin
               sreg_d    = in_data;
               div_cnt_d = '0;
               bit_cnt_d = '0;
               state_d   = ST_SHIFT;
`ifdef PISO_SHIFT_CTRL_PARITY_EN
               par_d     = ^in_data;
`endif
            end
         end
         ST_SHIFT: begin
            if (abort) begin
               state_d   = ST_IDLE;
               sreg_d    = '0;
               div_cnt_d = '0;
               bit_cnt_d = '0;
            end else if (period_end) begin
               div_cnt_d = '0;
               sreg_d    = {1'b0, sreg_q[N-1:1]};
               if (bit_cnt_q == BIT_LAST) begin
`ifdef PISO_SHIFT_CTRL_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
`endif
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end else begin
               div_cnt_d = div_cnt_q + 1'b1;
            end
         end
`ifdef PISO_SHIFT_CTRL_PARITY_EN
         ST_PARITY: begin
            if (abort) begin
               state_d   = ST_IDLE;
               sreg_d    = '0;
               div_cnt_d = '0;
               bit_cnt_d = '0;
            end else if (period_end) begin
               state_d   = ST_IDLE;
               div_cnt_d = '0;
               done_d    = 1'b1;
            end else begin
               div_cnt_d = div_cnt_q + 1'b1;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q   <= ST_IDLE;
         sreg_q    <= '0;
         div_cnt_q <= '0;
         bit_cnt_q <= '0;
         done_q    <= 1'b0;
`ifdef PISO_SHIFT_CTRL_PARITY_EN
         par_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         sreg_q    <= sreg_d;
         div_cnt_q <= div_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         done_q    <= done_d;
`ifdef PISO_SHIFT_CTRL_PARITY_EN
         par_q     <= par_d;
`endif
      end
   end

endmodule

// File: tb/tb_piso_shift_controller.sv
// Testbench for piso_shift_controller: two instances (N=8/DIV=4 and
// N=4/DIV=1) share stimulus and are compared every cycle against a
// frame-position model; directed traces pin the model with literal values.
module tb_piso_shift_controller;

`ifdef PISO_SHIFT_CTRL_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       n_reset, in_valid, abort;
   logic [7:0] din;
   logic       rdy8, so8, st8, bz8, dn8;
   logic       rdy4, so4, st4, bz4, dn4;

   piso_shift_controller #(.N(8), .DIV(4)) dut8 (
      .clk(clk), .n_reset(n_reset), .in_data(din), .in_valid(in_valid),
      .in_ready(rdy8), .abort(abort), .serial_out(so8),
      .shift_strobe(st8), .busy(bz8), .done(dn8));

   piso_shift_controller #(.N(4), .DIV(1)) dut4 (
      .clk(clk), .n_reset(n_reset), .in_data(din[3:0]), .in_valid(in_valid),
      .in_ready(rdy4), .abort(abort), .serial_out(so4),
      .shift_strobe(st4), .busy(bz4), .done(dn4));

   logic o_rdy[2], o_so[2], o_st[2], o_bz[2], o_dn[2];
   assign o_rdy[0] = rdy8; assign o_rdy[1] = rdy4;
   assign o_so[0]  = so8;  assign o_so[1]  = so4;
   assign o_st[0]  = st8;  assign o_st[1]  = st4;
   assign o_bz[0]  = bz8;  assign o_bz[1]  = bz4;
   assign o_dn[0]  = dn8;  assign o_dn[1]  = dn4;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int i, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s dut%0d: got %b expected %b at %0t", name, i, got, exp, $time);
      end
   endtask

   task automatic chk_i(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   // Model: position d (1-based cycle count since the handshake edge) of the
   // frame in progress, the captured word, and a pending done pulse.
   logic       m_act[2];
   int         m_d[2];
   logic [7:0] m_w[2];
   logic       m_done[2];

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         int n, dv, fr, idx;
         logic es, next_done;
         n  = (i == 0) ? 8 : 4;
         dv = (i == 0) ? 4 : 1;
         fr = n + PAR;
         if (!n_reset) begin
            m_act[i]  = 1'b0;
            m_done[i] = 1'b0;
         end
         es = 1'b1;
         if (m_act[i]) begin
            idx = (m_d[i] - 1) / dv;
            es  = (idx < n) ? m_w[i][idx] : ^m_w[i];
         end
         chk("in_ready", i, o_rdy[i], !m_act[i] && !abort);
         chk("busy", i, o_bz[i], m_act[i]);
         chk("serial_out", i, o_so[i], es);
         chk("shift_strobe", i, o_st[i], m_act[i] && (m_d[i] % dv == 0) && !abort);
         chk("done", i, o_dn[i], m_done[i]);
         next_done = m_act[i] && !abort && (m_d[i] == fr * dv);
         if (!n_reset) begin
            m_act[i]  = 1'b0;
            m_done[i] = 1'b0;
         end else begin
            m_done[i] = next_done;
            if (m_act[i]) begin
               if (abort || m_d[i] == fr * dv) m_act[i] = 1'b0;
               else m_d[i] = m_d[i] + 1;
            end else if (in_valid && !abort) begin
               m_act[i] = 1'b1;
               m_d[i]   = 1;
               m_w[i]   = din & ((i == 0) ? 8'hFF : 8'h0F);
            end
         end
      end
   end

   logic tr_so[64], tr_st[64], tr_dn[64], tr_bz[64];

   // Present w for one cycle (instance i must be idle) and record d=1..len.
   task automatic send_trace(input logic [7:0] w, input int i, input int len);
      @(posedge clk); #1 in_valid = 1'b1; din = w;
      @(posedge clk); #1 in_valid = 1'b0;
      for (int d = 1; d <= len; d++) begin
         @(negedge clk);
         tr_so[d] = o_so[i]; tr_st[d] = o_st[i];
         tr_dn[d] = o_dn[i]; tr_bz[d] = o_bz[i];
      end
   endtask

   task automatic idle(input int n);
      @(posedge clk); #1 in_valid = 1'b0; abort = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Wait (bounded) for a handshake on dut8; returns edges up to and
   // including the handshake edge, or -1 on timeout.
   task automatic wait_accept(output int edges);
      logic ok;
      edges = -1;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk); ok = rdy8 && in_valid;
         @(posedge clk);
         if (ok) begin edges = t + 1; break; end
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] pat_a5 = 8'hA5;
      logic [3:0] pat_9  = 4'h9;
      int cnt, e1, e2;

      n_reset = 1'b1; in_valid = 1'b0; abort = 1'b0; din = 8'h00;
      #1 n_reset = 1'b0;
      #1;
      chk("rst_serial", 0, so8, 1'b1); chk("rst_ready", 0, rdy8, 1'b1);
      chk("rst_busy", 0, bz8, 1'b0);   chk("rst_done", 0, dn8, 1'b0);
      chk("rst_strobe", 0, st8, 1'b0); chk("rst_serial", 1, so4, 1'b1);
      chk("rst_ready", 1, rdy4, 1'b1); chk("rst_busy", 1, bz4, 1'b0);
      repeat (3) @(posedge clk);
      #1 n_reset = 1'b1;
      idle(5);

      // 0xA5 on N=8, DIV=4: LSB first 1,0,1,0,0,1,0,1, four cycles each.
      send_trace(8'hA5, 0, 45);
      for (int b = 0; b < 8; b++)
         for (int c = 0; c < 4; c++)
            chk("a5_bit", 0, tr_so[1 + 4 * b + c], pat_a5[b]);
      cnt = 0;
      for (int d = 1; d <= 32; d++) if (tr_st[d]) cnt++;
      chk_i("a5_strobe_count", cnt, 8);
      chk("a5_strobe_last", 0, tr_st[32], 1'b1);
      cnt = 0;
      for (int d = 1; d <= 45; d++) if (tr_dn[d]) cnt++;
      chk_i("a5_done_count", cnt, 1);
`ifdef PISO_SHIFT_CTRL_PARITY_EN
      for (int d = 33; d <= 36; d++) chk("a5_parity", 0, tr_so[d], 1'b0);
      chk("a5_done_pos", 0, tr_dn[37], 1'b1);
      chk("a5_idle_at_done", 0, tr_bz[37], 1'b0);
`else
      chk("a5_done_pos", 0, tr_dn[33], 1'b1);
      chk("a5_idle_at_done", 0, tr_bz[33], 1'b0);
      chk("a5_idle_line", 0, tr_so[33], 1'b1);
`endif
      idle(10);

      // Back-to-back: 0x3C then 0xC3 with in_valid held.
      #1 in_valid = 1'b1; din = 8'h3C;
      wait_accept(e1);
      chk_i("b2b_first_accept", (e1 > 0) ? 1 : 0, 1);
      #1 din = 8'hC3;
      wait_accept(e2);
      #1 in_valid = 1'b0;
      chk_i("b2b_gap_edges", e2, 33 + 4 * PAR);
      cnt = 0;
      for (int d = 0; d < 45; d++) begin @(negedge clk); if (dn8) cnt++; end
      chk_i("b2b_second_done", cnt, 1);
      idle(5);

      // Abort during bit 3 of 0xFF, with in_valid held during the frame.
      @(posedge clk); #1 in_valid = 1'b1; din = 8'hFF;
      @(posedge clk); #1 din = 8'h55;
      repeat (13) @(posedge clk);
      #1 abort = 1'b1; in_valid = 1'b0;
      @(posedge clk); #1 abort = 1'b0;
      @(negedge clk);
      chk("abort_busy", 0, bz8, 1'b0);
      chk("abort_serial", 0, so8, 1'b1);
      chk("abort_done", 0, dn8, 1'b0);
      cnt = 0;
      for (int d = 0; d < 40; d++) begin @(negedge clk); if (dn8) cnt++; end
      chk_i("abort_no_done", cnt, 0);
      idle(5);

      // Asynchronous reset during bit 5, then 0x01.
      @(posedge clk); #1 in_valid = 1'b1; din = 8'hE7;
      @(posedge clk); #1 in_valid = 1'b0;
      repeat (21) @(posedge clk);
      @(negedge clk);
      #2 n_reset = 1'b0;
      #1;
      chk("arst_serial", 0, so8, 1'b1); chk("arst_ready", 0, rdy8, 1'b1);
      chk("arst_busy", 0, bz8, 1'b0);   chk("arst_done", 0, dn8, 1'b0);
      chk("arst_strobe", 0, st8, 1'b0);
      @(negedge clk);
      @(posedge clk); #1 n_reset = 1'b1;
      idle(3);
      send_trace(8'h01, 0, 40);
      for (int d = 1; d <= 32; d++) chk("w01_bit", 0, tr_so[d], (d <= 4));
`ifdef PISO_SHIFT_CTRL_PARITY_EN
      chk("w01_parity", 0, tr_so[34], 1'b1);
      chk("w01_done", 0, tr_dn[37], 1'b1);
`else
      chk("w01_done", 0, tr_dn[33], 1'b1);
`endif
      idle(10);

      // N=4, DIV=1: 0x9 -> 1,0,0,1, strobe every cycle.
      send_trace(8'h09, 1, 10);
      for (int d = 1; d <= 4; d++) begin
         chk("n4_bit", 1, tr_so[d], pat_9[d-1]);
         chk("n4_strobe", 1, tr_st[d], 1'b1);
      end
      cnt = 0;
      for (int d = 1; d <= 10; d++) if (tr_st[d]) cnt++;
      chk_i("n4_strobe_count", cnt, 4 + PAR);
`ifdef PISO_SHIFT_CTRL_PARITY_EN
      chk("n4_parity", 1, tr_so[5], 1'b0);
      chk("n4_done", 1, tr_dn[6], 1'b1);
`else
      chk("n4_done", 1, tr_dn[5], 1'b1);
      chk("n4_no_done_early", 1, tr_dn[4], 1'b0);
`endif
      idle(5);

      // Randomized traffic with occasional aborts.
      for (int t = 0; t < 3000; t++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         din      = 8'($urandom);
         abort    = ($urandom_range(0, 40) == 0);
         @(posedge clk); #1;
      end
      idle(50);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/piso_shift_controller.md
# piso_shift_controller

Controller that sequences an N-bit right-shifting serializer. It accepts a parallel word over a valid/ready handshake, loads it into an internal shift register, and shifts it out LSB-first at one bit per DIV clock cycles. It signals completion with a one-cycle done pulse and supports a synchronous abort. It sits between a parallel producer, such as a FIFO or CPU register, and a serial line or downstream serial-in shift register.

## Interface
- N, 8: data word width in bits; N >= 2.
- DIV, 4: bit period in clk cycles; DIV >= 1.
- clk  input  1  system clock, rising-edge.
- n_reset  input  1  reset, asynchronous, active-low.
- in_data  input  N  parallel word to serialize.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  controller can accept a word.
- abort  input  1  synchronous frame cancel.
- serial_out  output  1  serial data. Idle level is 1.
- shift_strobe  output  1  one-cycle pulse on the last cycle of each bit period.
- busy  output  1  a frame is in progress.
- done  output  1  one-cycle pulse after a frame completes normally.

## Operation
- The controller has three states: IDLE, SHIFT, and PARITY. PARITY exists only when the macro in Configuration is defined.
- Counters:
  - div_cnt: 0..DIV-1, width max(1, $clog2(DIV)).
  - bit_cnt: 0..N-1, width $clog2(N).
- Outputs by state:
  - in_ready = (state == IDLE) && !abort.
  - busy = (state != IDLE).
  - serial_out is 1 in IDLE, sreg[0] in SHIFT, and par_reg in PARITY.
- IDLE:
  - On a clk edge with in_valid && in_ready, the controller sets sreg <= in_data, div_cnt <= 0, bit_cnt <= 0, and state <= SHIFT.
  - par_reg <= ^in_data is loaded only when the macro is defined.
  - in_data is ignored when no handshake occurs.
- SHIFT:
  - div_cnt increments every cycle.
  - When div_cnt == DIV-1, shift_strobe = 1, div_cnt wraps to 0, and sreg <= {1'b0, sreg[N-1:1]}.
  - If bit_cnt == N-1 at that point, the next state is IDLE, or PARITY when the macro is defined. Otherwise bit_cnt increments.
- PARITY: the controller holds par_reg for one bit period, strobing on div_cnt == DIV-1, then moves to IDLE.
- done is a register. It is set on the edge that leaves the final bit state for IDLE and cleared on the following edge.
- abort (SHIFT or PARITY): at the next edge the controller goes to IDLE and clears div_cnt, bit_cnt, and sreg. No done pulse is generated. shift_strobe is suppressed in any cycle where abort = 1.
- abort in IDLE blocks acceptance for that cycle and has no other effect.
- in_valid while busy is ignored. Words are never dropped silently, because in_ready = 0.
- Reset values, applied immediately on n_reset low and including mid-frame:
  - state = IDLE, and sreg, par_reg, div_cnt, bit_cnt = 0.
  - serial_out = 1, in_ready = 1, busy = 0, shift_strobe = 0, done = 0.

## Timing
- The handshake completes at edge k.
  - Bit i (i = 0..N-1) drives serial_out during cycles k+1+i·DIV through k+(i+1)·DIV.
  - shift_strobe is high in cycle k+(i+1)·DIV.
- Without parity, done is high in cycle k+N·DIV+1. This is also the first IDLE cycle.
- With parity, the parity bit occupies cycles k+N·DIV+1 through k+(N+1)·DIV, and done is high in cycle k+(N+1)·DIV+1.
- Back-to-back frames: the earliest next handshake is at the end of the first IDLE cycle. Each frame is therefore followed by at least one cycle of serial_out = 1.
- Latency from handshake to first data bit is one cycle.
- DIV = 1: shift_strobe is high every cycle in SHIFT and PARITY.

## Configuration
- Macro PISO_SHIFT_CTRL_PARITY_EN.
  - Defined: the PARITY state and par_reg exist. An even-parity bit (XOR of all N data bits) is appended after bit N-1. A frame is N+1 bit periods.
  - Undefined: no parity logic. A frame is N bit periods, and SHIFT goes directly to IDLE.

## Test plan
- Reset: hold n_reset = 0 → serial_out = 1, in_ready = 1, busy = 0, done = 0, shift_strobe = 0.
- N = 8, DIV = 4, send 0xA5 with handshake at edge k → serial_out = 1,0,1,0,0,1,0,1, each bit for 4 cycles, and 8 strobes.
  - Without parity: done only in cycle k+33.
  - With the macro: parity bit 0 in cycles k+33 through k+36, and done in cycle k+37.
- Hold in_valid with 0x3C, then 0xC3 → second handshake at the end of the first IDLE cycle, one idle-1 gap cycle, and both words serialized in order with two done pulses.
- abort = 1 during bit 3 of 0xFF → next cycle IDLE, serial_out = 1, busy = 0, no done. in_valid asserted during the frame is not accepted.
- n_reset pulsed low in mid-frame during bit 5 → outputs take reset values without waiting for clk. After release, a new word 0x01 transmits correctly.
- N = 4, DIV = 1, send 0x9 → serial_out = 1,0,0,1 for one cycle each, shift_strobe high 4 consecutive cycles, and done in cycle k+5.
